// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: Decode-side hazard control bundle between the pipeline and the scoreboard.
interface hazard_scoreboard_if #(parameter int CNT_WIDTH = 32);
    logic                 InstrValidD;
    logic [4:0]           Rs1D;
    logic [4:0]           Rs2D;
    logic                 UsesRs1D;
    logic                 UsesRs2D;
    logic [4:0]           RdD;
    logic                 RegWriteD;
    logic [4:0]           RdW;
    logic                 RegWriteW;
    logic                 PCSrcE;
    logic                 StallF;
    logic                 StallD;
    logic                 FlushD;
    logic                 FlushE;
    logic                 IssueD;
    logic [31:0]          Busy;
    logic [CNT_WIDTH-1:0] StallCount;
    logic [CNT_WIDTH-1:0] FlushCount;
    modport master (
        output InstrValidD, Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdD, RegWriteD, RdW, RegWriteW, PCSrcE,
        input  StallF, StallD, FlushD, FlushE, IssueD, Busy, StallCount, FlushCount
    );
    modport slave (
        input  InstrValidD, Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdD, RegWriteD, RdW, RegWriteW, PCSrcE,
        output StallF, StallD, FlushD, FlushE, IssueD, Busy, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: register-pending scoreboard that stalls Decode on RAW/WAW and flushes on taken branches.
module hazard_scoreboard #(
    parameter int CNT_WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scoreboard_if.slave bus
);
    logic [31:1]          r_busy;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;
    logic [31:0]          w_busy;
    logic                 w_raw;
    logic                 w_waw;
    logic                 w_hazard;
    logic                 w_stall;
    logic                 w_issue;
    // bit 0 is tied low, so lookups of x0 never report a pending write
    assign w_busy   = {r_busy, 1'b0};
    assign w_raw    = bus.InstrValidD & ((bus.UsesRs1D & w_busy[bus.Rs1D]) | (bus.UsesRs2D & w_busy[bus.Rs2D]));
    assign w_waw    = bus.InstrValidD & bus.RegWriteD & w_busy[bus.RdD];
    assign w_hazard = w_raw | w_waw;
    assign w_stall  = rst_n & w_hazard & ~bus.PCSrcE;
    assign w_issue  = rst_n & bus.InstrValidD & ~w_hazard & ~bus.PCSrcE;
    assign bus.StallF     = w_stall;
    assign bus.StallD     = w_stall;
    assign bus.FlushD     = ~rst_n | bus.PCSrcE;
    assign bus.FlushE     = ~rst_n | w_hazard | bus.PCSrcE;
    assign bus.IssueD     = w_issue;
    assign bus.Busy       = w_busy;
    assign bus.StallCount = r_stall_cnt;
    assign bus.FlushCount = r_flush_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy      <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            for (int n = 1; n < 32; n++)
                r_busy[n] <= (w_issue & bus.RegWriteD & (bus.RdD == 5'(n))) |
                             (r_busy[n] & ~(bus.RegWriteW & (bus.RdW == 5'(n))));
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(w_stall & ~&r_stall_cnt);
            r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(bus.PCSrcE & ~&r_flush_cnt);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed pipeline scenarios checked every cycle against a register-pending model.
module tb_hazard_scoreboard;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_on = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   m_busy [32];
    int   m_stall = 0;
    int   m_flush = 0;
    logic [31:0] m_vec;
    logic m_hz;
    always #5 clk = ~clk;
    hazard_scoreboard_if #(.CNT_WIDTH(CW)) bus ();
    hazard_scoreboard #(.CNT_WIDTH(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    // a Decode instruction must wait if any register it reads or writes still has a write in flight
    assign m_hz = bus.InstrValidD && (
                  (bus.UsesRs1D && bus.Rs1D != 0 && m_busy[bus.Rs1D]) ||
                  (bus.UsesRs2D && bus.Rs2D != 0 && m_busy[bus.Rs2D]) ||
                  (bus.RegWriteD && bus.RdD != 0 && m_busy[bus.RdD]));
    always_comb begin
        m_vec = '0;
        for (int n = 1; n < 32; n++) m_vec[n] = m_busy[n];
    end
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < 32; n++) m_busy[n] <= 1'b0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            if (bus.RegWriteW && bus.RdW != 0) m_busy[bus.RdW] <= 1'b0;
            if (bus.InstrValidD && !m_hz && !bus.PCSrcE && bus.RegWriteD && bus.RdD != 0) m_busy[bus.RdD] <= 1'b1;
            m_stall <= (m_hz && !bus.PCSrcE) ? ((m_stall < MAX) ? m_stall + 1 : MAX) : m_stall;
            m_flush <= bus.PCSrcE ? ((m_flush < MAX) ? m_flush + 1 : MAX) : m_flush;
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc.StallF", 32'(bus.StallF), 32'(rst_n && m_hz && !bus.PCSrcE));
            chk("cyc.StallD", 32'(bus.StallD), 32'(rst_n && m_hz && !bus.PCSrcE));
            chk("cyc.FlushD", 32'(bus.FlushD), 32'(!rst_n || bus.PCSrcE));
            chk("cyc.FlushE", 32'(bus.FlushE), 32'(!rst_n || m_hz || bus.PCSrcE));
            chk("cyc.IssueD", 32'(bus.IssueD), 32'(rst_n && bus.InstrValidD && !m_hz && !bus.PCSrcE));
            chk("cyc.Busy", bus.Busy, m_vec);
            chk("cyc.StallCount", 32'(bus.StallCount), 32'(m_stall));
            chk("cyc.FlushCount", 32'(bus.FlushCount), 32'(m_flush));
        end
    end
    task automatic drv(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic [4:0] rdw, input logic rww, input logic br);
        bus.InstrValidD = v;
        bus.Rs1D = r1;
        bus.UsesRs1D = u1;
        bus.Rs2D = r2;
        bus.UsesRs2D = u2;
        bus.RdD = rd;
        bus.RegWriteD = rw;
        bus.RdW = rdw;
        bus.RegWriteW = rww;
        bus.PCSrcE = br;
        #1;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input logic [4:0] rdw, input logic rww);
        drv(0, 0, 0, 0, 0, 0, 0, rdw, rww, 0);
    endtask
    initial begin
        drv(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        chk("rst.FlushD", 32'(bus.FlushD), 32'd1);
        chk("rst.FlushE", 32'(bus.FlushE), 32'd1);
        chk("rst.StallD", 32'(bus.StallD), 32'd0);
        chk("rst.IssueD", 32'(bus.IssueD), 32'd0);
        tick();
        chk_on = 1'b1;
        chk("rst.Busy", bus.Busy, 32'h0);
        tick();
        rst_n = 1'b1;
        // independent stream: x1, x2, x3 with writebacks three cycles after issue
        drv(1, 10, 1, 11, 1, 1, 1, 0, 0, 0);
        chk("ind.IssueD", 32'(bus.IssueD), 32'd1);
        tick();
        drv(1, 10, 1, 11, 1, 2, 1, 0, 0, 0); tick();
        drv(1, 10, 1, 11, 1, 3, 1, 0, 0, 0); tick();
        idle(1, 1);
        chk("ind.Busy3", bus.Busy, 32'h0000_000E);
        tick();
        idle(2, 1);
        chk("ind.Busy4", bus.Busy, 32'h0000_000C);
        tick();
        idle(3, 1); tick();
        idle(0, 0);
        chk("ind.BusyEnd", bus.Busy, 32'h0);
        chk("ind.StallCount", 32'(bus.StallCount), 32'd0);
        tick();
        // RAW: add x5 then sub x6,x5,x7
        drv(1, 10, 1, 11, 1, 5, 1, 0, 0, 0); tick();
        drv(1, 5, 1, 7, 1, 6, 1, 0, 0, 0);
        chk("raw.StallD", 32'(bus.StallD), 32'd1);
        chk("raw.StallF", 32'(bus.StallF), 32'd1);
        chk("raw.FlushE", 32'(bus.FlushE), 32'd1);
        tick();
        drv(1, 5, 1, 7, 1, 6, 1, 0, 0, 0); tick();
        drv(1, 5, 1, 7, 1, 6, 1, 5, 1, 0);
        chk("raw.StallAtWB", 32'(bus.StallD), 32'd1);
        tick();
        drv(1, 5, 1, 7, 1, 6, 1, 0, 0, 0);
        chk("raw.IssueD", 32'(bus.IssueD), 32'd1);
        tick();
        idle(0, 0);
        chk("raw.StallCount", 32'(bus.StallCount), 32'd3);
        chk("raw.Busy", bus.Busy, 32'h0000_0040);
        tick();
        idle(0, 0); tick();
        idle(6, 1); tick();
        // WAW: lw x8 then lui x8; add x9,x0,x0 never stalls
        drv(1, 10, 1, 0, 0, 8, 1, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
        chk("waw.StallD", 32'(bus.StallD), 32'd1);
        tick();
        drv(1, 0, 0, 0, 0, 8, 1, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 8, 1, 8, 1, 0); tick();
        drv(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
        chk("waw.IssueD", 32'(bus.IssueD), 32'd1);
        tick();
        drv(1, 0, 1, 0, 1, 9, 1, 0, 0, 0);
        chk("x0.StallD", 32'(bus.StallD), 32'd0);
        chk("x0.IssueD", 32'(bus.IssueD), 32'd1);
        tick();
        idle(0, 1); tick();
        idle(8, 1);
        chk("x0wb.Busy", bus.Busy, 32'h0000_0300);
        tick();
        idle(9, 1); tick();
        idle(0, 0);
        chk("waw.BusyEnd", bus.Busy, 32'h0);
        chk("waw.StallCount", 32'(bus.StallCount), 32'd6);
        tick();
        // taken branch while Decode is stalled on x5
        drv(1, 10, 1, 11, 1, 5, 1, 0, 0, 0); tick();
        drv(1, 5, 1, 7, 1, 6, 1, 0, 0, 0); tick();
        drv(1, 5, 1, 7, 1, 6, 1, 0, 0, 1);
        chk("br.StallD", 32'(bus.StallD), 32'd0);
        chk("br.StallF", 32'(bus.StallF), 32'd0);
        chk("br.FlushD", 32'(bus.FlushD), 32'd1);
        chk("br.FlushE", 32'(bus.FlushE), 32'd1);
        chk("br.IssueD", 32'(bus.IssueD), 32'd0);
        tick();
        idle(5, 1);
        chk("br.FlushCount", 32'(bus.FlushCount), 32'd1);
        chk("br.Busy", bus.Busy, 32'h0000_0020);
        tick();
        idle(0, 0);
        chk("br.BusyEnd", bus.Busy, 32'h0);
        tick();
        // set wins when issue and writeback name the same register
        drv(1, 10, 1, 0, 0, 12, 1, 12, 1, 0); tick();
        idle(12, 1);
        chk("setwin.Busy", bus.Busy, 32'h0000_1000);
        tick();
        // reset mid-flight with x5 and x8 pending
        drv(1, 10, 1, 11, 1, 5, 1, 0, 0, 0); tick();
        drv(1, 10, 1, 11, 1, 8, 1, 0, 0, 0); tick();
        idle(0, 0);
        chk("mid.Busy", bus.Busy, 32'h0000_0120);
        chk("mid.StallCount", 32'(bus.StallCount), 32'd7);
        rst_n = 1'b0;
        drv(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        chk("mid.StallD", 32'(bus.StallD), 32'd0);
        chk("mid.FlushD", 32'(bus.FlushD), 32'd1);
        chk("mid.FlushE", 32'(bus.FlushE), 32'd1);
        tick();
        rst_n = 1'b1;
        idle(0, 0);
        chk("mid.BusyRst", bus.Busy, 32'h0);
        chk("mid.StallRst", 32'(bus.StallCount), 32'd0);
        chk("mid.FlushRst", 32'(bus.FlushCount), 32'd0);
        tick();
        // counter saturation
        drv(1, 10, 1, 11, 1, 5, 1, 0, 0, 0); tick();
        for (int i = 0; i < 20; i++) begin
            drv(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
            tick();
        end
        idle(0, 0);
        chk("sat.StallCount", 32'(bus.StallCount), 32'd15);
        for (int i = 0; i < 17; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            tick();
        end
        idle(5, 1);
        chk("sat.FlushCount", 32'(bus.FlushCount), 32'd15);
        chk("sat.Busy", bus.Busy, 32'h0000_0020);
        tick();
        idle(0, 0); tick();
        chk("end.Busy", bus.Busy, 32'h0);
        tick();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
